// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if
//   Bundles the two-requester command side and the single-port memory side
//   of mem_rr_arbiter.
//   Requester side : req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i (to arbiter)
//                    req_ready_o, req_rdata_o, req_err_o              (from arbiter)
//   Memory side    : valid_o, wr_rd_o, addr_o, wdata_o                (from arbiter)
//                    rdata_i, ready_i                                 (to arbiter)
//   Requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH] / [k*DATA_WIDTH +: DATA_WIDTH].
//   modport slave  : the arbiter's view.
//   modport master : the surrounding environment (requesters plus memory).
interface mem_rr_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [1:0]              req_valid_i;
   logic [1:0]              req_wr_rd_i;
   logic [2*ADDR_WIDTH-1:0] req_addr_i;
   logic [2*DATA_WIDTH-1:0] req_wdata_i;
   logic [1:0]              req_ready_o;
   logic [DATA_WIDTH-1:0]   req_rdata_o;
   logic                    req_err_o;
   logic                    valid_o;
   logic                    wr_rd_o;
   logic [ADDR_WIDTH-1:0]   addr_o;
   logic [DATA_WIDTH-1:0]   wdata_o;
   logic [DATA_WIDTH-1:0]   rdata_i;
   logic                    ready_i;

   modport slave (
      input  req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i, rdata_i, ready_i,
      output req_ready_o, req_rdata_o, req_err_o, valid_o, wr_rd_o, addr_o, wdata_o
   );

   modport master (
      output req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i, rdata_i, ready_i,
      input  req_ready_o, req_rdata_o, req_err_o, valid_o, wr_rd_o, addr_o, wdata_o
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Two-requester round-robin arbiter in front of a single-port memory.
//   It latches the winning requester's command, holds it on the memory port
//   until ready_i, then returns a one-cycle ready pulse (plus read data for
//   reads) to that requester. Every output is registered.
// Ports
//   clk : clock, all logic on posedge
//   rst : asynchronous reset, active-high
//   bus : mem_rr_arbiter_if.slave (requester command/completion and memory port)
// Build option
//   MEM_ARB_TIMEOUT_EN : when defined, an ISSUE phase lasting TIMEOUT_CYCLES
//   cycles without ready_i is aborted and completes with req_err_o=1.
//   When it is not defined, ISSUE waits indefinitely and req_err_o stays 0.
module mem_rr_arbiter #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic            clk,
   input logic            rst,
   mem_rr_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

   state_t state, state_nxt;

   logic                  rr_ptr, rr_ptr_nxt;
   logic                  gnt, gnt_nxt;
   logic                  win;
   logic                  timeout_hit;

   logic                  valid_r, valid_nxt;
   logic                  wr_rd_r, wr_rd_nxt;
   logic [ADDR_WIDTH-1:0] addr_r, addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_r, wdata_nxt;
   logic [1:0]            ready_r, ready_nxt;
   logic [DATA_WIDTH-1:0] rdata_r, rdata_nxt;
   logic                  err_r, err_nxt;

   // Preferred requester wins if it is asking, otherwise the other one.
   assign win = bus.req_valid_i[rr_ptr] ? rr_ptr : ~rr_ptr;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Counts completed ISSUE cycles without ready_i; held at 0 outside a
   // transaction so it starts from zero on every entry into ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (state != ISSUE) begin
         cnt <= '0;
      end else if (!bus.ready_i) begin
         cnt <= cnt + 1'b1;
      end
   end

   // ready_i on the limit cycle takes priority over the abort.
   assign timeout_hit = (state == ISSUE) && !bus.ready_i && (cnt == CNT_LIMIT);
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rr_ptr  <= 1'b0;
         gnt     <= 1'b0;
         valid_r <= 1'b0;
         wr_rd_r <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
         ready_r <= '0;
         rdata_r <= '0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         gnt     <= gnt_nxt;
         valid_r <= valid_nxt;
         wr_rd_r <= wr_rd_nxt;
         addr_r  <= addr_nxt;
         wdata_r <= wdata_nxt;
         ready_r <= ready_nxt;
         rdata_r <= rdata_nxt;
         err_r   <= err_nxt;
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|bus.req_valid_i) state_nxt = ISSUE;
         ISSUE:   if (bus.ready_i || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and arbitration state
   always_comb begin
      rr_ptr_nxt = rr_ptr;
      gnt_nxt    = gnt;
      valid_nxt  = valid_r;
      wr_rd_nxt  = wr_rd_r;
      addr_nxt   = addr_r;
      wdata_nxt  = wdata_r;
      ready_nxt  = ready_r;
      rdata_nxt  = rdata_r;
      err_nxt    = err_r;
      case (state)
         IDLE: begin
            if (|bus.req_valid_i) begin
               gnt_nxt    = win;
               rr_ptr_nxt = ~win;
               valid_nxt  = 1'b1;
               wr_rd_nxt  = bus.req_wr_rd_i[win];
               addr_nxt   = win ? bus.req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                : bus.req_addr_i[0 +: ADDR_WIDTH];
               wdata_nxt  = win ? bus.req_wdata_i[DATA_WIDTH +: DATA_WIDTH]
                                : bus.req_wdata_i[0 +: DATA_WIDTH];
            end
         end
         ISSUE: begin
            if (bus.ready_i) begin
               valid_nxt = 1'b0;
               ready_nxt = gnt ? 2'b10 : 2'b01;
               rdata_nxt = wr_rd_r ? '0 : bus.rdata_i;
               err_nxt   = 1'b0;
            end else if (timeout_hit) begin
               valid_nxt = 1'b0;
               ready_nxt = gnt ? 2'b10 : 2'b01;
               rdata_nxt = '0;
               err_nxt   = 1'b1;
            end
         end
         DONE: begin
            ready_nxt = '0;
            rdata_nxt = '0;
            err_nxt   = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.valid_o     = valid_r;
   assign bus.wr_rd_o     = wr_rd_r;
   assign bus.addr_o      = addr_r;
   assign bus.wdata_o     = wdata_r;
   assign bus.req_ready_o = ready_r;
   assign bus.req_rdata_o = rdata_r;
   assign bus.req_err_o   = err_r;

endmodule
